// File: rtl/macc_mult_seq.sv
// Sequencer computing C = A x B for 2^S x 2^S matrices held in 1-cycle-latency BRAMs.
// Optional macro MACC_SEQ_SAT_EN: signed operands, wide accumulator, saturated C writes.
module macc_mult_seq #(
   parameter int ADDR_MSB         = 11,
   parameter int MAT_IDX_SIZE_MSB = 3,
   parameter int DATA_W           = 32
) (
   input  logic                        CLK,
   input  logic                        RST_L,
   input  logic                        start,
   input  logic [MAT_IDX_SIZE_MSB:0]   idx_size,
   output logic                        busy,
   output logic                        done,
   output logic [ADDR_MSB:0]           a_addr,
   output logic [ADDR_MSB:0]           b_addr,
   input  logic [DATA_W-1:0]           a_rdata,
   input  logic [DATA_W-1:0]           b_rdata,
   output logic [ADDR_MSB:0]           c_addr,
   output logic                        c_we,
   output logic [DATA_W-1:0]           c_wdata
);

   localparam int ADDR_W = ADDR_MSB + 1;
   localparam int S_MAX  = ADDR_W / 2;          // largest S whose N*N fits the RAM
   localparam int IDX_W  = S_MAX;
   localparam int S_W    = $clog2(S_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_LAST,
      ST_WR,
      ST_DONE
   } state_t;

`ifdef MACC_SEQ_SAT_EN
   localparam int ACC_W = 2 * DATA_W + S_MAX;
`else
   localparam int ACC_W = DATA_W;
`endif

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [S_W-1:0]         r_s;
   logic [S_W-1:0]         w_s_clamp;
   logic [IDX_W-1:0]       r_i, r_j, r_k;
   logic [IDX_W-1:0]       w_i_nxt, w_j_nxt, w_k_nxt;
   logic [IDX_W-1:0]       w_nmax;
   logic [ACC_W-1:0]       r_acc;
   logic [ACC_W-1:0]       w_prod_ext;
   logic [ACC_W-1:0]       w_acc_sum;
   logic [DATA_W-1:0]      w_wr_val;
   logic                   w_acc_en;
   logic                   w_acc_clr;
   logic                   r_busy, r_done, r_c_we;
   logic [ADDR_MSB:0]      r_a_addr, r_b_addr, r_c_addr;
   logic [DATA_W-1:0]      r_c_wdata;

   function automatic logic [ADDR_MSB:0] mk_addr(input logic [IDX_W-1:0] hi,
                                                 input logic [IDX_W-1:0] lo,
                                                 input logic [S_W-1:0]   s);
      return (ADDR_W'(hi) << s) | ADDR_W'(lo);
   endfunction

   assign w_s_clamp = (idx_size > (MAT_IDX_SIZE_MSB + 1)'(S_MAX)) ? S_W'(S_MAX) : S_W'(idx_size);
   assign w_nmax    = IDX_W'((1 << r_s) - 1);
   assign w_acc_sum = r_acc + w_prod_ext;

`ifdef MACC_SEQ_SAT_EN
   logic signed [2*DATA_W-1:0] w_prod;
   logic [ACC_W-DATA_W:0]      w_hi;

   assign w_prod     = $signed(a_rdata) * $signed(b_rdata);
   assign w_prod_ext = {{S_MAX{w_prod[2*DATA_W-1]}}, w_prod};
   assign w_hi       = w_acc_sum[ACC_W-1:DATA_W-1];

   // The sum fits signed DATA_W only when every bit above the sign position matches it.
   always_comb begin
      w_wr_val = w_acc_sum[DATA_W-1:0];
      if (!((&w_hi) || (~|w_hi))) begin
         w_wr_val = w_hi[ACC_W-DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end
`else
   assign w_prod_ext = a_rdata * b_rdata;
   assign w_wr_val   = w_acc_sum;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_i_nxt     = r_i;
      w_j_nxt     = r_j;
      w_k_nxt     = r_k;
      w_acc_en    = 1'b0;
      w_acc_clr   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
               w_i_nxt     = '0;
               w_j_nxt     = '0;
               w_k_nxt     = '0;
               w_acc_clr   = 1'b1;
            end
         end
         ST_RUN: begin
            // Data for k-1 arrives while k is being addressed.
            w_acc_en = (r_k != '0);
            if (r_k == w_nmax) begin
               w_state_nxt = ST_LAST;
            end else begin
               w_k_nxt = r_k + IDX_W'(1);
            end
         end
         ST_LAST: begin
            w_acc_en    = 1'b1;
            w_state_nxt = ST_WR;
         end
         ST_WR: begin
            w_acc_clr = 1'b1;
            w_k_nxt   = '0;
            if (r_j == w_nmax) begin
               w_j_nxt = '0;
               w_i_nxt = r_i + IDX_W'(1);
            end else begin
               w_j_nxt = r_j + IDX_W'(1);
            end
            w_state_nxt = ((r_i == w_nmax) && (r_j == w_nmax)) ? ST_DONE : ST_RUN;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_L) begin
         r_state   <= ST_IDLE;
         r_s       <= '0;
         r_i       <= '0;
         r_j       <= '0;
         r_k       <= '0;
         r_acc     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_c_we    <= 1'b0;
         r_a_addr  <= '0;
         r_b_addr  <= '0;
         r_c_addr  <= '0;
         r_c_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_i     <= w_i_nxt;
         r_j     <= w_j_nxt;
         r_k     <= w_k_nxt;
         if ((r_state == ST_IDLE) && start) r_s <= w_s_clamp;
         if (w_acc_clr)     r_acc <= '0;
         else if (w_acc_en) r_acc <= w_acc_sum;
         // Addresses follow the next-state indices so they are stable for the whole RUN cycle.
         if (w_state_nxt == ST_RUN) begin
            r_a_addr <= mk_addr(w_i_nxt, w_k_nxt, r_s);
            r_b_addr <= mk_addr(w_k_nxt, w_j_nxt, r_s);
         end
         if (w_state_nxt == ST_WR) begin
            r_c_addr  <= mk_addr(r_i, r_j, r_s);
            r_c_wdata <= w_wr_val;
         end
         r_busy <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_LAST) || (w_state_nxt == ST_WR);
         r_done <= (w_state_nxt == ST_DONE);
         r_c_we <= (w_state_nxt == ST_WR);
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign c_we    = r_c_we;
   assign a_addr  = r_a_addr;
   assign b_addr  = r_b_addr;
   assign c_addr  = r_c_addr;
   assign c_wdata = r_c_wdata;

endmodule

// File: tb/tb_macc_mult_seq.sv
// Directed bench for macc_mult_seq: BRAM models, C-write scoreboard, timing and clamp checks.
// Cycle 0 is the cycle in which start is first presented; it is accepted on the next rising edge.
module tb_macc_mult_seq;

   logic        CLK = 1'b0;
   logic        RST_L = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  idx_size = '0;
   logic        busy, done, c_we;
   logic [11:0] a_addr, b_addr, c_addr;
   logic [31:0] a_rdata, b_rdata, c_wdata;

   logic [31:0] a_mem [4096];
   logic [31:0] b_mem [4096];
   logic [31:0] exp_q [$];
   int          checks = 0;
   int          failures = 0;

   macc_mult_seq dut (
      .CLK      (CLK),
      .RST_L    (RST_L),
      .start    (start),
      .idx_size (idx_size),
      .busy     (busy),
      .done     (done),
      .a_addr   (a_addr),
      .b_addr   (b_addr),
      .a_rdata  (a_rdata),
      .b_rdata  (b_rdata),
      .c_addr   (c_addr),
      .c_we     (c_we),
      .c_wdata  (c_wdata)
   );

   always #5 CLK = ~CLK;

   // BRAMs: one-cycle read latency, no output register.
   always @(posedge CLK) begin
      a_rdata <= a_mem[a_addr];
      b_rdata <= b_mem[b_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 4096; a++) begin
         a_mem[a] = '0;
         b_mem[a] = '0;
      end
   endtask

   task automatic load_2x2();
      clear_mem();
      a_mem[0] = 32'd1; a_mem[1] = 32'd2; a_mem[2] = 32'd3; a_mem[3] = 32'd4;
      b_mem[0] = 32'd5; b_mem[1] = 32'd6; b_mem[2] = 32'd7; b_mem[3] = 32'd8;
   endtask

   // Runs one multiply and checks every C write against exp_q, plus write timing and done timing.
   task automatic run_mult(input string tag, input logic [3:0] sz, input int n, input bit hammer);
      int          cyc;
      int          widx;
      int          ndone;
      int          tdone;
      int          total;
      logic [31:0] e;
      total = n * n * (n + 2);
      widx  = 0;
      ndone = 0;
      tdone = -1;
      @(posedge CLK); #1;
      start    = 1'b1;
      idx_size = sz;
      cyc      = 0;
      while (cyc < total + 10) begin
         @(posedge CLK); cyc++; #1;
         start = hammer && (cyc < total + 1);
         if (hammer) idx_size = 4'd0;
         @(negedge CLK);
         if (cyc == 1) check({tag, " busy_first_run"}, {31'b0, busy}, 32'd1);
         if (c_we) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check({tag, " c_addr"}, 32'(c_addr), 32'(widx));
            check({tag, " c_wdata"}, c_wdata, e);
            check({tag, " c_we_cycle"}, 32'(cyc), 32'((widx + 1) * (n + 2)));
            widx++;
         end
         if (done) begin
            ndone++;
            tdone = cyc;
            check({tag, " busy_in_done"}, {31'b0, busy}, 32'd0);
         end
      end
      check({tag, " write_count"}, 32'(widx), 32'(n * n));
      check({tag, " done_count"}, 32'(ndone), 32'd1);
      check({tag, " done_cycle"}, 32'(tdone), 32'(total + 1));
      exp_q.delete();
   endtask

   initial begin
      int cyc;
      int nwr;
      clear_mem();

      // Reset state
      RST_L = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst busy", {31'b0, busy}, 32'd0);
      check("rst done", {31'b0, done}, 32'd0);
      check("rst c_we", {31'b0, c_we}, 32'd0);
      check("rst a_addr", 32'(a_addr), 32'd0);
      check("rst b_addr", 32'(b_addr), 32'd0);
      check("rst c_addr", 32'(c_addr), 32'd0);
      check("rst c_wdata", c_wdata, 32'd0);
      RST_L = 1'b1;

      // 1x1: 3*5
      clear_mem();
      a_mem[0] = 32'd3; b_mem[0] = 32'd5;
      exp_q.push_back(32'd15);
      run_mult("s0", 4'd0, 1, 1'b0);

      // 2x2: [[1,2],[3,4]] x [[5,6],[7,8]]
      load_2x2();
      exp_q.push_back(32'd19); exp_q.push_back(32'd22);
      exp_q.push_back(32'd43); exp_q.push_back(32'd50);
      run_mult("s1", 4'd1, 2, 1'b0);

      // Overflowing product
      clear_mem();
      a_mem[0] = 32'h7FFF_FFFF; b_mem[0] = 32'd2;
`ifdef MACC_SEQ_SAT_EN
      exp_q.push_back(32'h7FFF_FFFF);
`else
      exp_q.push_back(32'hFFFF_FFFE);
`endif
      run_mult("ovf", 4'd0, 1, 1'b0);

      // Reset during RUN of element 1 (cycles 5..6), then a clean rerun
      load_2x2();
      @(posedge CLK); #1;
      start = 1'b1; idx_size = 4'd1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (4) @(posedge CLK);
      #1 RST_L = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check("midrst busy", {31'b0, busy}, 32'd0);
      check("midrst c_we", {31'b0, c_we}, 32'd0);
      check("midrst done", {31'b0, done}, 32'd0);
      check("midrst a_addr", 32'(a_addr), 32'd0);
      RST_L = 1'b1;
      exp_q.push_back(32'd19); exp_q.push_back(32'd22);
      exp_q.push_back(32'd43); exp_q.push_back(32'd50);
      run_mult("after_rst", 4'd1, 2, 1'b0);

      // start held high and idx_size changed during the run
      exp_q.push_back(32'd19); exp_q.push_back(32'd22);
      exp_q.push_back(32'd43); exp_q.push_back(32'd50);
      run_mult("hammer", 4'd1, 2, 1'b1);

      // idx_size=9 clamps to S=6: identity 64x64, first two elements then abort
      clear_mem();
      for (int d = 0; d < 64; d++) begin
         a_mem[d * 65] = 32'd1;
         b_mem[d * 65] = 32'd1;
      end
      @(posedge CLK); #1;
      start = 1'b1; idx_size = 4'd9;
      cyc = 0;
      nwr = 0;
      while (cyc < 134) begin
         @(posedge CLK); cyc++; #1;
         start = 1'b0;
         @(negedge CLK);
         if (cyc == 11) begin
            check("clamp a_addr k10", 32'(a_addr), 32'd10);
            check("clamp b_addr k10", 32'(b_addr), 32'd640);
         end
         if (cyc == 64) begin
            check("clamp a_addr k63", 32'(a_addr), 32'd63);
            check("clamp b_addr k63", 32'(b_addr), 32'd4032);
         end
         if (cyc == 67) begin
            check("clamp a_addr j1", 32'(a_addr), 32'd0);
            check("clamp b_addr j1", 32'(b_addr), 32'd1);
         end
         if (c_we) begin
            check("clamp c_we_cycle", 32'(cyc), 32'((nwr + 1) * 66));
            check("clamp c_addr", 32'(c_addr), 32'(nwr));
            check("clamp c_wdata", c_wdata, (nwr == 0) ? 32'd1 : 32'd0);
            nwr++;
         end
      end
      check("clamp write_count", 32'(nwr), 32'd2);
      RST_L = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check("clamp abort busy", {31'b0, busy}, 32'd0);
      RST_L = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
